// File: rtl/rca_aprox_pkg.sv
// Shared constants and the majority helper for the approximate ripple-carry adder.
package rca_aprox_pkg;

  localparam logic        MODE_EXACT  = 1'b0;
  localparam logic        MODE_APPROX = 1'b1;
  localparam int unsigned ERR_CNT_W   = 16;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/rca_seg.sv
// Combinational SEG-bit ripple segment; bit positions below APPROX_BITS use
// approximate cells (sum = ~carry_out) when mode selects approximation.
module rca_seg
  import rca_aprox_pkg::*;
#(
  parameter int unsigned SEG         = 4,
  parameter int unsigned APPROX_BITS = 2
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  input  logic           mode,
  input  logic [31:0]    base,
  output logic [SEG-1:0] s,
  output logic           co
);

  logic cy;
  logic cn;

  always_comb begin
    cy = cin;
    cn = 1'b0;
    s  = '0;
    for (int unsigned i = 0; i < SEG; i++) begin
      cn = maj(a[i], b[i], cy);
      if ((mode == MODE_APPROX) && ((base + i) < APPROX_BITS)) begin
        s[i] = ~cn;
      end else begin
        s[i] = a[i] ^ b[i] ^ cy;
      end
      cy = cn;
    end
    co = cy;
  end

endmodule

// File: rtl/rca_aproximado_pipe.sv
// Pipelined ripple-carry adder with per-transaction approximate low bits.
// Define RCA_ERR_MON_EN to build the run-time approximation error monitor.
module rca_aproximado_pipe
  import rca_aprox_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned APPROX_BITS = 2,
  parameter int unsigned STAGES      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 Cin,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH:0]       S,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH:0]       err_max
);

  localparam int unsigned SEG = WIDTH / STAGES;
  localparam int unsigned SW  = WIDTH + 1;

  logic                 adv;
  logic [STAGES:0]      vld_q;
  logic [STAGES:0]      md_q;
  logic [STAGES:0]      cy_q;
  logic [WIDTH-1:0]     a_q   [STAGES+1];
  logic [WIDTH-1:0]     b_q   [STAGES+1];
  logic [WIDTH-1:0]     sum_q [STAGES+1];
  logic [SEG-1:0]       seg_s [STAGES];
  logic [STAGES-1:0]    seg_co;

  // Whole pipe advances together; a stalled output freezes every stage.
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES];
  assign S         = {cy_q[STAGES], sum_q[STAGES]};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    rca_seg #(
      .SEG         (SEG),
      .APPROX_BITS (APPROX_BITS)
    ) u_seg (
      .a    (a_q[k][k*SEG +: SEG]),
      .b    (b_q[k][k*SEG +: SEG]),
      .cin  (cy_q[k]),
      .mode (md_q[k]),
      .base (32'(k * SEG)),
      .s    (seg_s[k]),
      .co   (seg_co[k])
    );
  end

  // Slot 0 captures operands; slot k+1 holds the result of segment k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      md_q  <= '0;
      cy_q  <= '0;
      for (int unsigned k = 0; k <= STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q[0] <= in_valid;
      md_q[0]  <= mode;
      cy_q[0]  <= Cin;
      a_q[0]   <= A;
      b_q[0]   <= B;
      sum_q[0] <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        vld_q[k+1] <= vld_q[k];
        md_q[k+1]  <= md_q[k];
        cy_q[k+1]  <= seg_co[k];
        a_q[k+1]   <= a_q[k];
        b_q[k+1]   <= b_q[k];
        sum_q[k+1] <= sum_q[k];
        sum_q[k+1][k*SEG +: SEG] <= seg_s[k];
      end
    end
  end

`ifdef RCA_ERR_MON_EN
  logic [WIDTH:0] ex_q [STAGES+1];
  logic [WIDTH:0] ex_out;
  logic [WIDTH:0] diff_c;
  logic           hit_c;

  assign ex_out = ex_q[STAGES];
  assign diff_c = (ex_out >= S) ? (ex_out - S) : (S - ex_out);
  assign hit_c  = out_valid & out_ready & (md_q[STAGES] == MODE_APPROX) & (diff_c != '0);

  // Shadow exact sum rides alongside each transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k <= STAGES; k++) ex_q[k] <= '0;
    end else if (adv) begin
      ex_q[0] <= SW'(A) + SW'(B) + SW'(Cin);
      for (int unsigned k = 0; k < STAGES; k++) ex_q[k+1] <= ex_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
      err_max   <= '0;
    end else if (err_clr) begin
      err_count <= '0;
      err_max   <= '0;
    end else if (hit_c) begin
      if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
      if (diff_c > err_max) err_max <= diff_c;
    end
  end
`else
  logic unused_mon;

  assign unused_mon = ^{err_clr, md_q[STAGES]};
  assign err_count  = '0;
  assign err_max    = '0;
`endif

endmodule

// File: tb/tb_rca_aproximado_pipe.sv
// Self-checking bench for rca_aproximado_pipe (WIDTH=8, APPROX_BITS=2, STAGES=2);
// follows RCA_ERR_MON_EN so monitor expectations match the build.
module tb_rca_aproximado_pipe;

`ifdef RCA_ERR_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic        clk, rst_n, in_valid, in_ready, Cin, mode, out_valid, out_ready, err_clr;
  logic [7:0]  A, B;
  logic [8:0]  S, err_max;
  logic [15:0] err_count;

  rca_aproximado_pipe #(.WIDTH(8), .APPROX_BITS(2), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .S(S), .err_clr(err_clr), .err_count(err_count),
    .err_max(err_max)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       mode;
    logic [8:0] s;
  } vec_t;

  typedef struct packed {
    logic [8:0] s;
    logic       m;
    logic [8:0] ex;
  } sb_t;

  int          nchk = 0;
  int          nerr = 0;
  sb_t         q[$];
  logic [8:0]  drv_exp;
  logic [15:0] m_cnt = '0;
  logic [8:0]  m_max = '0;
  vec_t        tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference adder written from the cell definitions.
  function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b,
                                         input logic c, input logic m);
    logic [8:0] r;
    logic       cy, co;
    r  = '0;
    cy = c;
    for (int i = 0; i < 8; i++) begin
      co = (a[i] & b[i]) | (a[i] & cy) | (b[i] & cy);
      r[i] = (m && i < 2) ? ~co : (a[i] ^ b[i] ^ cy);
      cy = co;
    end
    r[8] = cy;
    return r;
  endfunction

  // Scoreboard: push on input transfer, pop on output transfer, track monitor model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("stale_out_valid", 32'(out_valid), 32'd0);
        end else begin
          sb_t        e;
          logic [8:0] d;
          e = q[0];
          chk("S", 32'(S), 32'(e.s));
          if (!out_ready) chk("in_ready_stall", 32'(in_ready), 32'd0);
          if (out_ready) begin
            chk("err_count", 32'(err_count), 32'(m_cnt));
            chk("err_max", 32'(err_max), 32'(m_max));
            void'(q.pop_front());
            d = (e.ex >= e.s) ? e.ex - e.s : e.s - e.ex;
            if (MON && e.m && d != 0) begin
              if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
              if (d > m_max) m_max = d;
            end
          end
        end
      end
      if (err_clr) begin
        m_cnt = '0;
        m_max = '0;
      end
      if (in_valid && in_ready)
        q.push_back('{s: drv_exp, m: mode, ex: 9'(A) + 9'(B) + 9'(Cin)});
    end
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic m, input logic [8:0] e);
    A = a; B = b; Cin = c; mode = m; drv_exp = e; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_out();
    for (int i = 0; i < 10 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("wait_out_valid", 32'(out_valid), 32'd1);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc, rm;

    clk = 0; rst_n = 0; in_valid = 0; A = 0; B = 0; Cin = 0; mode = 0;
    out_ready = 1; err_clr = 0; drv_exp = 0;

    tbl[0] = '{8'hFF, 8'h01, 1'b0, 1'b1, 9'h100};
    tbl[1] = '{8'h10, 8'h20, 1'b0, 1'b0, 9'h030};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 9'h080};
    tbl[3] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF};
    tbl[4] = '{8'h03, 8'h01, 1'b0, 1'b1, 9'h004};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 1'b1, 9'h003};
    tbl[6] = '{8'h02, 8'h02, 1'b0, 1'b1, 9'h005};
    tbl[7] = '{8'hAA, 8'h55, 1'b1, 1'b0, 9'h100};
    tbl[8] = '{8'h04, 8'h04, 1'b0, 1'b1, 9'h00B};

    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_S", 32'(S), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_err_max", 32'(err_max), 32'd0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // Latency and first approximate result.
    drive(8'h01, 8'h00, 1'b0, 1'b1, 9'h003);
    in_valid = 0;
    @(posedge clk); #1;
    chk("lat_n1_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_n2_out_valid", 32'(out_valid), 32'd1);
    chk("lat_S", 32'(S), 32'h003);
    @(posedge clk); #1;
    chk("first_err_count", 32'(err_count), MON ? 32'd1 : 32'd0);
    chk("first_err_max", 32'(err_max), MON ? 32'd2 : 32'd0);

    // Same operands exact: counters unchanged.
    drive(8'h01, 8'h00, 1'b0, 1'b0, 9'h001);
    in_valid = 0;
    drain();
    chk("exact_err_count", 32'(err_count), MON ? 32'd1 : 32'd0);
    chk("exact_err_max", 32'(err_max), MON ? 32'd2 : 32'd0);

    for (int i = 0; i < 9; i++) drive(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].mode, tbl[i].s);
    in_valid = 0;
    drain();

    // Back-to-back with a 3-cycle output stall.
    drive(8'h10, 8'h20, 1'b0, 1'b0, 9'h030);
    drive(8'h7F, 8'h01, 1'b0, 1'b0, 9'h080);
    in_valid = 0;
    wait_out();
    out_ready = 0;
    chk("stall_S0", 32'(S), 32'h030);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_S", 32'(S), 32'h030);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("release_S", 32'(S), 32'h080);
    chk("release_out_valid", 32'(out_valid), 32'd1);
    drain();

    // Random traffic with random backpressure and mode changes after capture.
    for (int i = 0; i < 80; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rm = 1'($urandom);
      A = ra; B = rb; Cin = rc; mode = rm; drv_exp = ref_add(ra, rb, rc, rm);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    drain();

    // Reset with transactions in flight.
    out_ready = 0;
    drive(8'h11, 8'h22, 1'b0, 1'b0, 9'h033);
    drive(8'h01, 8'h01, 1'b0, 1'b1, ref_add(8'h01, 8'h01, 1'b0, 1'b1));
    drive(8'h40, 8'h40, 1'b1, 1'b0, 9'h081);
    in_valid = 0;
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst_n = 0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_S", 32'(S), 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    q.delete();
    m_cnt = '0; m_max = '0;
    @(negedge clk) rst_n = 1;
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Accumulate errors, then clear on the same cycle as an erroneous transfer.
    drive(8'h01, 8'h00, 1'b0, 1'b1, 9'h003);
    drive(8'h02, 8'h02, 1'b0, 1'b1, 9'h005);
    in_valid = 0;
    drain();
    chk("acc_err_count", 32'(err_count), MON ? 32'd2 : 32'd0);
    chk("acc_err_max", 32'(err_max), MON ? 32'd2 : 32'd0);
    drive(8'h00, 8'h00, 1'b1, 1'b1, 9'h003);
    in_valid = 0;
    wait_out();
    err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0;
    chk("clr_err_count", 32'(err_count), 32'd0);
    chk("clr_err_max", 32'(err_max), 32'd0);
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    drain();
    chk("final_err_count", 32'(err_count), 32'(m_cnt));
    chk("final_err_max", 32'(err_max), 32'(m_max));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
